// File: rtl/alu_sequencer_if.sv
// Bundle of the request, response and ALU-side signals of the ALU sequencer.
// The slave view belongs to the sequencer; the master view is the surrounding
// environment (request producer, response consumer and the external ALU).
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_setf;
    logic [2:0]  req_cond;

    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [3:0]  resp_flags;
    logic        resp_taken;

    logic [3:0]  alu_opcode;
    logic [15:0] alu_src1;
    logic [15:0] alu_src2;
    logic        alu_out_en;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_setf, req_cond,
        input  resp_ready, alu_out, alu_flags,
        output req_ready, resp_valid, resp_data, resp_flags, resp_taken,
        output alu_opcode, alu_src1, alu_src2, alu_out_en
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_setf, req_cond,
        output resp_ready, alu_out, alu_flags,
        input  req_ready, resp_valid, resp_data, resp_flags, resp_taken,
        input  alu_opcode, alu_src1, alu_src2, alu_out_en
    );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one request at a time, holds its operands on an
// external registered ALU, lets the ALU update its flags when asked, and
// returns the result, flags and evaluated branch condition.
// Flags are ordered O C N Z (bit 3 down to bit 0).
module alu_sequencer (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLAG  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        setf_q;
    logic [2:0]  cond_q;
    logic [15:0] respData_q;

    logic        accept;
    logic        taken;

    assign accept = bus.req_valid && (state_q == IDLE);

    // State register; reset returns to IDLE from anywhere, even mid-operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the request on a handshake only, so requests outside IDLE are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 4'd0;
            a_q    <= 16'd0;
            b_q    <= 16'd0;
            setf_q <= 1'b0;
            cond_q <= 3'd0;
        end else if (accept) begin
            op_q   <= bus.req_op;
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            setf_q <= bus.req_setf;
            cond_q <= bus.req_cond;
        end
    end

    // Capture the ALU result on the FLAG->RESP edge so it stays stable while in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            respData_q <= 16'd0;
        end else if (state_q == FLAG) begin
            respData_q <= bus.alu_out;
        end
    end

    // Next-state and handshake/enable outputs; the flag enable fires in FLAG
    // while the operands are still held so the ALU flags match this operation.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.alu_out_en = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = FLAG;
            end
            FLAG: begin
                bus.alu_out_en = setf_q;
                state_d        = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Branch condition decode on the current ALU flags {O, C, N, Z}.
    always_comb begin
        taken = 1'b1;
        case (cond_q)
            3'b000:  taken = 1'b1;
            3'b001:  taken = bus.alu_flags[0];
            3'b010:  taken = ~bus.alu_flags[0];
            3'b011:  taken = bus.alu_flags[2];
            3'b100:  taken = ~bus.alu_flags[2];
            3'b101:  taken = bus.alu_flags[1];
            3'b110:  taken = ~bus.alu_flags[1];
            3'b111:  taken = bus.alu_flags[3];
            default: taken = 1'b1;
        endcase
    end

    assign bus.alu_opcode = op_q;
    assign bus.alu_src1   = a_q;
    assign bus.alu_src2   = b_q;
    assign bus.resp_data  = respData_q;
    assign bus.resp_flags = bus.alu_flags;
    assign bus.resp_taken = taken;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural registered ALU.
// ALU opcodes used here: 0000 ADD, 0001 SUB (C = borrow), 0010 AND, 0011 OR,
// 1000 XOR, everything else yields 0x0000. Flags are {O, C, N, Z}.
module tb_alu_sequencer;

    logic clk;
    logic rst;

    alu_sequencer_if bus();

    alu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        setf;
        logic [2:0]  cond;
        logic [15:0] expData;
        logic [3:0]  expFlags;
        logic        expTaken;
    } vec_t;

    vec_t vecs [11];

    int total;
    int bad;

    logic [15:0] aluOutQ;
    logic [3:0]  aluFlagsQ;

    assign bus.alu_out   = aluOutQ;
    assign bus.alu_flags = aluFlagsQ;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] aluResult(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b1000: return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [3:0] aluFlagCalc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        logic [15:0] r;
        logic        c;
        logic        o;
        r = aluResult(op, a, b);
        c = 1'b0;
        o = 1'b0;
        if (op == 4'b0000) begin
            sum = {1'b0, a} + {1'b0, b};
            c   = sum[16];
            o   = (a[15] == b[15]) && (r[15] != a[15]);
        end else if (op == 4'b0001) begin
            c = (a < b);
            o = (a[15] != b[15]) && (r[15] != a[15]);
        end
        return {o, c, r[15], (r == 16'h0000)};
    endfunction

    // External ALU: result registered every edge, flags only on an enabled edge.
    always @(posedge clk) begin
        if (rst) begin
            aluOutQ   <= 16'h0000;
            aluFlagsQ <= 4'h0;
        end else begin
            aluOutQ <= aluResult(bus.alu_opcode, bus.alu_src1, bus.alu_src2);
            if (bus.alu_out_en) begin
                aluFlagsQ <= aluFlagCalc(bus.alu_opcode, bus.alu_src1, bus.alu_src2);
            end
        end
    end

    // Last-resort guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Walk from the accept edge to RESP; edges counts rising edges including the accept edge.
    task automatic waitResp(input string tag, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, output int edges, output int enCount);
        edges   = 1;
        enCount = 0;
        while (!bus.resp_valid && edges < 8) begin
            if (bus.alu_out_en) enCount++;
            if (edges == 1) begin
                checkOutput({tag, "_opcode"}, {12'h000, bus.alu_opcode}, {12'h000, op});
                checkOutput({tag, "_src1"}, bus.alu_src1, a);
                checkOutput({tag, "_src2"}, bus.alu_src2, b);
            end
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int    edges;
        int    enCount;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        bus.req_op     = v.op;
        bus.req_a      = v.a;
        bus.req_b      = v.b;
        bus.req_setf   = v.setf;
        bus.req_cond   = v.cond;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        checkOutput({tag, "_ready"}, {15'd0, bus.req_ready}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        waitResp(tag, v.op, v.a, v.b, edges, enCount);
        checkOutput({tag, "_latency"}, 16'(edges), 16'd3);
        checkOutput({tag, "_out_en"}, 16'(enCount), v.setf ? 16'd1 : 16'd0);
        checkOutput({tag, "_data"}, bus.resp_data, v.expData);
        checkOutput({tag, "_flags"}, {12'h000, bus.resp_flags}, {12'h000, v.expFlags});
        checkOutput({tag, "_taken"}, {15'd0, bus.resp_taken}, {15'd0, v.expTaken});
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checkOutput({tag, "_idle"}, {15'd0, bus.req_ready}, 16'd1);
    endtask

    initial begin
        int edges;
        int enCount;
        int validSeen;

        total = 0;
        bad   = 0;

        //             op       a        b        setf  cond    data     flags    taken
        vecs[0]  = '{4'b0000, 16'h0003, 16'h0004, 1'b1, 3'b000, 16'h0007, 4'b0000, 1'b1};
        vecs[1]  = '{4'b0001, 16'h0005, 16'h0005, 1'b1, 3'b001, 16'h0000, 4'b0001, 1'b1};
        vecs[2]  = '{4'b0000, 16'hFFFF, 16'h0001, 1'b1, 3'b011, 16'h0000, 4'b0101, 1'b1};
        vecs[3]  = '{4'b0010, 16'h00F0, 16'h0F00, 1'b0, 3'b011, 16'h0000, 4'b0101, 1'b1};
        vecs[4]  = '{4'b0011, 16'h00F0, 16'h0F00, 1'b1, 3'b010, 16'h0FF0, 4'b0000, 1'b1};
        vecs[5]  = '{4'b0001, 16'h0001, 16'h0002, 1'b1, 3'b101, 16'hFFFF, 4'b0110, 1'b1};
        vecs[6]  = '{4'b0000, 16'h7FFF, 16'h0001, 1'b1, 3'b111, 16'h8000, 4'b1010, 1'b1};
        vecs[7]  = '{4'b0000, 16'h0001, 16'h0001, 1'b1, 3'b001, 16'h0002, 4'b0000, 1'b0};
        vecs[8]  = '{4'b0101, 16'h1234, 16'h5678, 1'b1, 3'b100, 16'h0000, 4'b0001, 1'b1};
        vecs[9]  = '{4'b1000, 16'h00FF, 16'h00FF, 1'b0, 3'b110, 16'h0000, 4'b0001, 1'b1};
        vecs[10] = '{4'b0000, 16'h0000, 16'h0000, 1'b0, 3'b010, 16'h0000, 4'b0001, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_op     = 4'h0;
        bus.req_a      = 16'h0000;
        bus.req_b      = 16'h0000;
        bus.req_setf   = 1'b0;
        bus.req_cond   = 3'b000;
        bus.resp_ready = 1'b0;

        // Reset held for two edges.
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_req_ready", {15'd0, bus.req_ready}, 16'd1);
        checkOutput("rst_resp_valid", {15'd0, bus.resp_valid}, 16'd0);
        checkOutput("rst_out_en", {15'd0, bus.alu_out_en}, 16'd0);
        checkOutput("rst_opcode", {12'h000, bus.alu_opcode}, 16'd0);
        checkOutput("rst_src1", bus.alu_src1, 16'd0);
        checkOutput("rst_src2", bus.alu_src2, 16'd0);
        checkOutput("rst_data", bus.resp_data, 16'd0);
        checkOutput("rst_taken", {15'd0, bus.resp_taken}, 16'd1);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Backpressure: response held five cycles while a second request waits.
        @(negedge clk);
        bus.req_op    = 4'b0000;
        bus.req_a     = 16'h1111;
        bus.req_b     = 16'h2222;
        bus.req_setf  = 1'b1;
        bus.req_cond  = 3'b000;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_op = 4'b0001;
        bus.req_a  = 16'h0009;
        bus.req_b  = 16'h0004;
        waitResp("bp1", 4'b0000, 16'h1111, 16'h2222, edges, enCount);
        checkOutput("bp1_latency", 16'(edges), 16'd3);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp_hold%0d_valid", c), {15'd0, bus.resp_valid}, 16'd1);
            checkOutput($sformatf("bp_hold%0d_data", c), bus.resp_data, 16'h3333);
            checkOutput($sformatf("bp_hold%0d_ready", c), {15'd0, bus.req_ready}, 16'd0);
            checkOutput($sformatf("bp_hold%0d_src1", c), bus.alu_src1, 16'h1111);
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("bp_flags", {12'h000, bus.resp_flags}, 16'h0000);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checkOutput("bp_back_idle", {15'd0, bus.req_ready}, 16'd1);
        checkOutput("bp_back_src1", bus.alu_src1, 16'h1111);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        waitResp("bp2", 4'b0001, 16'h0009, 16'h0004, edges, enCount);
        checkOutput("bp2_latency", 16'(edges), 16'd3);
        checkOutput("bp2_data", bus.resp_data, 16'h0005);
        checkOutput("bp2_flags", {12'h000, bus.resp_flags}, 16'h0000);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;

        // Reset while in FLAG: operation abandoned, no response.
        bus.req_op    = 4'b0000;
        bus.req_a     = 16'h0001;
        bus.req_b     = 16'h0002;
        bus.req_setf  = 1'b1;
        bus.req_cond  = 3'b000;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("flagrst_in_flag", {15'd0, bus.alu_out_en}, 16'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("flagrst_ready", {15'd0, bus.req_ready}, 16'd1);
        checkOutput("flagrst_out_en", {15'd0, bus.alu_out_en}, 16'd0);
        checkOutput("flagrst_opcode_src1", bus.alu_src1, 16'd0);
        validSeen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.resp_valid) validSeen++;
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("flagrst_no_resp", 16'(validSeen), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
